// File: rtl/rom_access_pkg.sv
// Shared types and constants for the PSRAM access sequencer.
// Holds the sequencer state encoding, counter width and byte-lane select values.
package rom_access_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNES_RD = 3'd1,
        ST_SNES_WR = 3'd2,
        ST_MCU_RD  = 3'd3,
        ST_MCU_WR  = 3'd4
    } rom_state_e;

    // Byte-address bit 0 values: even bytes live on the low lane.
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    function automatic logic is_rd_state(input rom_state_e s);
        return (s == ST_SNES_RD) || (s == ST_MCU_RD);
    endfunction

    function automatic logic is_wr_state(input rom_state_e s);
        return (s == ST_SNES_WR) || (s == ST_MCU_WR);
    endfunction

endpackage

// File: rtl/rom_lane_mux.sv
// Byte/word steering between the 8-bit request side and the 16-bit PSRAM.
// Generates the active-low byte-lane enables from address bit 0 and access type.
module rom_lane_mux
    import rom_access_pkg::*;
(
    input  logic        active,
    input  logic        is_write,
    input  logic        lane_sel,
    input  logic [7:0]  wr_byte,
    output logic [15:0] wr_word,
    output logic        bhe_n,
    output logic        ble_n,
    input  logic        rd_sel,
    input  logic [15:0] rd_word,
    output logic [7:0]  rd_byte
);

    // Lane enables, duplicated write data and read byte selection.
    always_comb begin
        wr_word = {wr_byte, wr_byte};
        bhe_n   = 1'b1;
        ble_n   = 1'b1;
        rd_byte = rd_word[7:0];
        if (!active) begin
            bhe_n = 1'b1;
            ble_n = 1'b1;
        end else if (!is_write) begin
            bhe_n = 1'b0;
            ble_n = 1'b0;
        end else if (lane_sel == LANE_HI) begin
            bhe_n = 1'b0;
        end else begin
            ble_n = 1'b0;
        end
        if (rd_sel == LANE_HI) begin
            rd_byte = rd_word[15:8];
        end else begin
            rd_byte = rd_word[7:0];
        end
    end

endmodule

// File: rtl/rom_access_seq.sv
// PSRAM access sequencer: SNES reads/writes take priority, MCU accesses fill gaps.
// All PSRAM strobes are registered; each access lasts ROM_CYCLE_LEN clocks.
module rom_access_seq
    import rom_access_pkg::*;
#(
    parameter int ROM_CYCLE_LEN = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_RD_start,
    input  logic        SNES_WR_end,
    input  logic [23:0] SNES_ROM_ADDR,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic [7:0]  SNES_DATA_IN,
    output logic [7:0]  SNES_DATA_OUT,
    input  logic        MCU_RRQ,
    input  logic        MCU_WRQ,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_DOUT,
    output logic [7:0]  MCU_DIN,
    output logic        MCU_RDY,
    output logic [22:0] ROM_ADDR,
    output logic [15:0] ROM_DATA_OUT,
    input  logic [15:0] ROM_DATA_IN,
    output logic        ROM_DATA_OE,
    output logic        ROM_CE_n,
    output logic        ROM_OE_n,
    output logic        ROM_WE_n,
    output logic        ROM_BHE_n,
    output logic        ROM_BLE_n
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_CYCLE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    rom_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    logic        snes_rd_pend_r, snes_wr_pend_r, mcu_pend_r, mcu_wr_r;
    logic [23:0] snes_rd_addr_r, snes_wr_addr_r, mcu_addr_r;
    logic [7:0]  snes_wr_data_r, mcu_data_r;
    logic        mcu_rdy_r, cur_a0_r;
    logic [7:0]  snes_data_out_r, mcu_din_r;
    logic [22:0] rom_addr_r;
    logic [15:0] rom_data_out_r;
    logic        rom_data_oe_r, rom_ce_n_r, rom_oe_n_r, rom_we_n_r, rom_bhe_n_r, rom_ble_n_r;

    logic        snes_rd_cap_s, snes_wr_cap_s, mcu_cap_s;
    logic        rd_req_s, wr_req_s, mcu_req_s, mcu_is_wr_s;
    logic [23:0] rd_addr_s, wr_addr_s, mcu_addr_s;
    logic [7:0]  wr_data_s, mcu_data_s;
    logic        take_rd_s, take_wr_s, take_mcu_s, gap_s, cycle_end_s;
    logic [23:0] next_addr_s;
    logic [7:0]  next_data_s;
    logic        ce_n_nxt_s, oe_n_nxt_s, we_n_nxt_s, data_oe_nxt_s;
    logic [15:0] wr_word_s;
    logic        bhe_n_nxt_s, ble_n_nxt_s;
    logic [7:0]  rd_byte_s;

    // A request seen this clock is visible immediately so an idle sequencer starts without a bubble.
    assign snes_rd_cap_s = SNES_RD_start & ROM_HIT;
    assign snes_wr_cap_s = SNES_WR_end & ROM_HIT & IS_WRITABLE;
    assign mcu_cap_s     = (MCU_RRQ | MCU_WRQ) & mcu_rdy_r;
    assign rd_req_s      = snes_rd_pend_r | snes_rd_cap_s;
    assign wr_req_s      = snes_wr_pend_r | snes_wr_cap_s;
    assign mcu_req_s     = mcu_pend_r | mcu_cap_s;
    assign rd_addr_s     = snes_rd_cap_s ? SNES_ROM_ADDR : snes_rd_addr_r;
    assign wr_addr_s     = snes_wr_cap_s ? SNES_ROM_ADDR : snes_wr_addr_r;
    assign wr_data_s     = snes_wr_cap_s ? SNES_DATA_IN : snes_wr_data_r;
    assign mcu_addr_s    = mcu_cap_s ? MCU_ADDR : mcu_addr_r;
    assign mcu_data_s    = mcu_cap_s ? MCU_DOUT : mcu_data_r;
    assign mcu_is_wr_s   = mcu_cap_s ? ~MCU_RRQ : mcu_wr_r;
    assign cycle_end_s   = (cnt_r == CNT_ZERO);

    // Next-state arbitration, cycle counter and next strobe values.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        take_rd_s   = 1'b0;
        take_wr_s   = 1'b0;
        take_mcu_s  = 1'b0;
        next_addr_s = {rom_addr_r, cur_a0_r};
        next_data_s = rom_data_out_r[7:0];
        if (cycle_end_s) begin
            cnt_nxt_s = CNT_LOAD;
            if (rd_req_s) begin
                state_nxt_s = ST_SNES_RD;
                next_addr_s = rd_addr_s;
                take_rd_s   = 1'b1;
            end else if (wr_req_s) begin
                state_nxt_s = ST_SNES_WR;
                next_addr_s = wr_addr_s;
                next_data_s = wr_data_s;
                take_wr_s   = 1'b1;
            end else if (mcu_req_s) begin
                state_nxt_s = mcu_is_wr_s ? ST_MCU_WR : ST_MCU_RD;
                next_addr_s = mcu_addr_s;
                next_data_s = mcu_data_s;
                take_mcu_s  = 1'b1;
            end else begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        end else begin
            cnt_nxt_s = cnt_r - 4'd1;
        end
        // After a read, OE_n/WE_n stay high for the first clock of a chained access.
        gap_s         = is_rd_state(state_r) && cycle_end_s;
        ce_n_nxt_s    = (state_nxt_s == ST_IDLE);
        oe_n_nxt_s    = !(is_rd_state(state_nxt_s) && !gap_s);
        we_n_nxt_s    = !(is_wr_state(state_nxt_s) && (cnt_nxt_s != CNT_ZERO) && !gap_s);
        data_oe_nxt_s = is_wr_state(state_nxt_s);
    end

    rom_lane_mux u_lane_mux (
        .active   (state_nxt_s != ST_IDLE),
        .is_write (is_wr_state(state_nxt_s)),
        .lane_sel (next_addr_s[0]),
        .wr_byte  (next_data_s),
        .wr_word  (wr_word_s),
        .bhe_n    (bhe_n_nxt_s),
        .ble_n    (ble_n_nxt_s),
        .rd_sel   (cur_a0_r),
        .rd_word  (ROM_DATA_IN),
        .rd_byte  (rd_byte_s)
    );

    // State, request latches, read data capture and registered PSRAM strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            snes_rd_pend_r  <= 1'b0;
            snes_wr_pend_r  <= 1'b0;
            mcu_pend_r      <= 1'b0;
            mcu_wr_r        <= 1'b0;
            snes_rd_addr_r  <= 24'd0;
            snes_wr_addr_r  <= 24'd0;
            snes_wr_data_r  <= 8'd0;
            mcu_addr_r      <= 24'd0;
            mcu_data_r      <= 8'd0;
            mcu_rdy_r       <= 1'b1;
            cur_a0_r        <= 1'b0;
            snes_data_out_r <= 8'd0;
            mcu_din_r       <= 8'd0;
            rom_addr_r      <= 23'd0;
            rom_data_out_r  <= 16'd0;
            rom_data_oe_r   <= 1'b0;
            rom_ce_n_r      <= 1'b1;
            rom_oe_n_r      <= 1'b1;
            rom_we_n_r      <= 1'b1;
            rom_bhe_n_r     <= 1'b1;
            rom_ble_n_r     <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;

            if (take_rd_s)          snes_rd_pend_r <= 1'b0;
            else if (snes_rd_cap_s) snes_rd_pend_r <= 1'b1;
            if (snes_rd_cap_s)      snes_rd_addr_r <= SNES_ROM_ADDR;

            if (take_wr_s)          snes_wr_pend_r <= 1'b0;
            else if (snes_wr_cap_s) snes_wr_pend_r <= 1'b1;
            if (snes_wr_cap_s) begin
                snes_wr_addr_r <= SNES_ROM_ADDR;
                snes_wr_data_r <= SNES_DATA_IN;
            end

            if (take_mcu_s)     mcu_pend_r <= 1'b0;
            else if (mcu_cap_s) mcu_pend_r <= 1'b1;
            if (mcu_cap_s) begin
                mcu_wr_r   <= ~MCU_RRQ;
                mcu_addr_r <= MCU_ADDR;
                mcu_data_r <= MCU_DOUT;
            end

            if (mcu_cap_s) begin
                mcu_rdy_r <= 1'b0;
            end else if (cycle_end_s && ((state_r == ST_MCU_RD) || (state_r == ST_MCU_WR))) begin
                mcu_rdy_r <= 1'b1;
            end

            if (cycle_end_s && (state_r == ST_SNES_RD)) snes_data_out_r <= rd_byte_s;
            if (cycle_end_s && (state_r == ST_MCU_RD))  mcu_din_r       <= rd_byte_s;

            cur_a0_r      <= next_addr_s[0];
            rom_addr_r    <= next_addr_s[23:1];
            if (take_wr_s || (take_mcu_s && mcu_is_wr_s)) rom_data_out_r <= wr_word_s;
            rom_data_oe_r <= data_oe_nxt_s;
            rom_ce_n_r    <= ce_n_nxt_s;
            rom_oe_n_r    <= oe_n_nxt_s;
            rom_we_n_r    <= we_n_nxt_s;
            rom_bhe_n_r   <= bhe_n_nxt_s;
            rom_ble_n_r   <= ble_n_nxt_s;
        end
    end

    assign SNES_DATA_OUT = snes_data_out_r;
    assign MCU_DIN       = mcu_din_r;
    assign MCU_RDY       = mcu_rdy_r;
    assign ROM_ADDR      = rom_addr_r;
    assign ROM_DATA_OUT  = rom_data_out_r;
    assign ROM_DATA_OE   = rom_data_oe_r;
    assign ROM_CE_n      = rom_ce_n_r;
    assign ROM_OE_n      = rom_oe_n_r;
    assign ROM_WE_n      = rom_we_n_r;
    assign ROM_BHE_n     = rom_bhe_n_r;
    assign ROM_BLE_n     = rom_ble_n_r;

endmodule
